beep_gen: RTL
=============

BEEP_GEN -- requirements
Module: beep_gen

Interface
REQ-001 SHALL have parameter SYSCLK_FREQUENCY, default 1000, meaning clk frequency in 100 kHz units.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, meaning output sample rate in Hz.
REQ-003 SHALL have parameter HALF_PERIOD, default 24, meaning tone half-period in samples (1 kHz at 48 kHz).
REQ-004 SHALL have parameter DECAY_SHIFT, default 11, meaning envelope decay shift per sample.
REQ-005 SHALL have parameter DURATION, default 9600, meaning tone length in samples when the envelope is compiled out.
REQ-006 SHALL have port clk, input, 1 bit, meaning system clock; the block has one clock.
REQ-007 SHALL have port reset_n, input, 1 bit, meaning reset; reset is asynchronous and active-low.
REQ-008 SHALL have port trigger, input, 1 bit, meaning asynchronous level (OSD status bit); a rising edge starts a beep.
REQ-009 SHALL have port audio_l, output, 16 bits, meaning signed two's-complement left sample for the sigma-delta DAC.
REQ-010 SHALL have port audio_r, output, 16 bits, meaning signed right sample, always equal to audio_l.
REQ-011 SHALL have port busy, output, 1 bit, meaning high while in PLAY.

Function
REQ-012 SHALL synchronise trigger through 2 flops, then detect the rising edge with one more register; PLAY is entered on the 3rd clk edge after trigger rises.
REQ-013 SHALL generate a one-clk sample tick every CLKS = SYSCLK_FREQUENCY*100000/SAMPLE_RATE clocks (integer division), free-running from reset.
REQ-014 SHALL implement states IDLE and PLAY: IDLE->PLAY on trigger edge; PLAY->IDLE on termination (REQ-018/REQ-022); PLAY->PLAY (restart) on trigger edge.
REQ-015 SHALL, on entering or restarting PLAY, load amplitude 0x7FFF, clear the half-period counter, set phase to positive, and clear the duration counter.
REQ-016 SHALL, in PLAY on each tick, increment the half-period counter; at HALF_PERIOD-1 it wraps to 0 and the phase toggles.
REQ-017 SHALL, on each tick in PLAY, register audio = phase ? +amp : -amp, with amp 15-bit unsigned zero-extended; outputs change only on ticks and hold between them.
REQ-018 SHALL, in IDLE, drive audio_l = audio_r = 0; the transition to IDLE zeroes the outputs on the same clk.
REQ-019 SHALL give a trigger edge coinciding with a tick priority: restart occurs and that tick outputs +0x7FFF.

Reset
REQ-020 SHALL, with reset_n low, asynchronously force IDLE, audio_l = audio_r = 0, busy = 0, all counters and sync flops = 0; reset mid-beep aborts silently, and a trigger held high through reset release produces no beep.

Configuration
REQ-021 SHALL, with BEEP_ENVELOPE_EN defined, compute each tick amp <= amp - (amp >> DECAY_SHIFT), and PLAY ends on the tick where the new amp is < 16.
REQ-022 SHALL, without BEEP_ENVELOPE_EN, hold amp constant at 0x4000 (loaded instead of 0x7FFF) and end PLAY after DURATION ticks.

Structure
REQ-023 SHALL place the state enum (IDLE, PLAY) and the constants AMP_INIT = 0x7FFF, AMP_FIXED = 0x4000, AMP_FLOOR = 16 in package beep_pkg.
REQ-024 SHALL implement the sample-tick divider as sub-module beep_tick (parameter CLKS; ports clk, reset_n, tick).

Verification (SYSCLK_FREQUENCY=1, SAMPLE_RATE=10000 -> tick every 10 clk; HALF_PERIOD=4; DECAY_SHIFT=3; DURATION=8)
REQ-025 SHALL verify that after reset release with trigger=0 for 200 clk, audio_l = audio_r = 0 and busy = 0 throughout.
REQ-026 SHALL verify that with envelope enabled, a pulse of trigger gives busy high 3 clk later, successive tick outputs +0x7FFF, +0x7000, +0x6200, +0x55C0, then negative values starting at -0x4B08, and decay to IDLE with output 0.
REQ-027 SHALL verify that a retrigger at the 6th tick of a beep restores +0x7FFF on the next tick and restarts the phase count.
REQ-028 SHALL verify that asserting reset_n low mid-beep immediately zeroes the outputs and busy, and that a trigger held high across reset release yields no beep until it falls and rises again.
REQ-029 SHALL verify that with envelope disabled, a trigger yields exactly 8 ticks of +0x4000 ×4 then -0x4000 ×4, after which busy = 0 and the output is 0.
REQ-030 SHALL verify that a trigger edge on the same clk as a tick outputs +0x7FFF on that tick.

Source files
------------

// File: rtl/beep_pkg.sv
// Shared types and constants for the beep generator.
// Consumed by beep_gen (BEEP_ENVELOPE_EN selects envelope vs fixed-length tone).
package beep_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } beep_state_t;

    localparam logic [14:0] AMP_INIT  = 15'h7FFF;
    localparam logic [14:0] AMP_FIXED = 15'h4000;
    localparam logic [14:0] AMP_FLOOR = 15'd16;

    // Square-wave sample: zero-extended magnitude, negated on the low half-cycle.
    function automatic logic [15:0] signed_sample(input logic positive, input logic [14:0] amp);
        logic [15:0] mag;
        mag = {1'b0, amp};
        return positive ? mag : (16'd0 - mag);
    endfunction

endpackage

// File: rtl/beep_tick.sv
// Free-running sample-rate strobe: one-clock tick every CLKS clocks after reset.
module beep_tick #(
    parameter int CLKS = 10
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (CLKS > 1) ? $clog2(CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/beep_gen.sv
// Square-wave beep for the OSD: a rising trigger edge plays a 1 kHz tone.
// BEEP_ENVELOPE_EN: exponential decay envelope; otherwise fixed amplitude for DURATION ticks.
module beep_gen
    import beep_pkg::*;
#(
    parameter int SYSCLK_FREQUENCY = 1000,
    parameter int SAMPLE_RATE      = 48000,
    parameter int HALF_PERIOD      = 24,
    parameter int DECAY_SHIFT      = 11,
    parameter int DURATION         = 9600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trigger,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        busy
);

    localparam int CLKS  = SYSCLK_FREQUENCY * 100000 / SAMPLE_RATE;
    localparam int HP_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int DUR_W = (DURATION > 0) ? $clog2(DURATION + 1) : 1;
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

`ifdef BEEP_ENVELOPE_EN
    localparam bit          ENV_EN   = 1'b1;
    localparam logic [14:0] AMP_LOAD = AMP_INIT;
`else
    localparam bit          ENV_EN   = 1'b0;
    localparam logic [14:0] AMP_LOAD = AMP_FIXED;
`endif
    localparam logic [14:0] LOAD_DEC = AMP_LOAD - (AMP_LOAD >> DECAY_SHIFT);

    beep_state_t state, state_nxt;

    logic trig_s1, trig_s2, trig_s3;
    logic fill_s1, fill_s2, armed;
    logic trig_edge, tick;
    logic load, step, stop, done;

    logic [14:0]      amp, amp_base, amp_dec, amp_stepped;
    logic [HP_W-1:0]  hp, hp_base;
    logic             phase, phase_base;
    logic [DUR_W-1:0] dur, dur_base;
    logic [15:0]      audio;

    beep_tick #(.CLKS(CLKS)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Edge detection is armed only after a genuine low has passed the synchroniser,
    // so a trigger held high through reset release does not start a beep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
            fill_s1 <= 1'b0;
            fill_s2 <= 1'b0;
            armed   <= 1'b0;
        end else begin
            trig_s1 <= trigger;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
            fill_s1 <= 1'b1;
            fill_s2 <= fill_s1;
            armed   <= armed | (fill_s2 & ~trig_s2);
        end
    end

    assign trig_edge = trig_s2 & ~trig_s3 & armed;

    assign amp_dec = amp - (amp >> DECAY_SHIFT);
    assign done    = ENV_EN ? (amp_dec < AMP_FLOOR) : (dur == DUR_W'(DURATION));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A trigger edge outranks termination; a coincident tick is consumed by the fresh beep.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        stop      = 1'b0;
        case (state)
            IDLE: begin
                if (trig_edge) begin
                    state_nxt = PLAY;
                    load      = 1'b1;
                    step      = tick;
                end
            end
            PLAY: begin
                if (trig_edge) begin
                    load = 1'b1;
                    step = tick;
                end else if (tick) begin
                    if (done) begin
                        state_nxt = IDLE;
                        stop      = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        amp_base    = load ? AMP_LOAD : amp;
        hp_base     = load ? '0 : hp;
        phase_base  = load ? 1'b1 : phase;
        dur_base    = load ? '0 : dur;
        amp_stepped = ENV_EN ? (load ? LOAD_DEC : amp_dec) : amp_base;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            amp   <= '0;
            hp    <= '0;
            phase <= 1'b0;
            dur   <= '0;
            audio <= '0;
        end else if (stop) begin
            audio <= '0;
        end else if (step) begin
            audio <= signed_sample(phase_base, amp_base);
            amp   <= amp_stepped;
            dur   <= dur_base + DUR_W'(1);
            if (hp_base == HP_LAST) begin
                hp    <= '0;
                phase <= ~phase_base;
            end else begin
                hp    <= hp_base + HP_W'(1);
                phase <= phase_base;
            end
        end else if (load) begin
            amp   <= AMP_LOAD;
            hp    <= '0;
            phase <= 1'b1;
            dur   <= '0;
        end
    end

    assign audio_l = audio;
    assign audio_r = audio;
    assign busy    = (state == PLAY);

endmodule
